// File: rtl/systolic_pkg.sv
// Shared defaults, index helpers and row-entry layout for the systolic result collector.
package systolic_pkg;

  localparam int ARRAY_SIZE_DEF = 4;
  localparam int DATA_W_DEF     = 32;
  localparam int IDX_W          = $clog2(ARRAY_SIZE_DEF);

  typedef struct packed {
    logic [IDX_W-1:0]                     idx;
    logic [ARRAY_SIZE_DEF*DATA_W_DEF-1:0] elems;
  } row_entry_t;

  function automatic int unsigned row_of(input int unsigned k, input int unsigned n);
    return k / n;
  endfunction

  function automatic int unsigned col_of(input int unsigned k, input int unsigned n);
    return k % n;
  endfunction

endpackage

// File: rtl/collector_row_fifo.sv
// Synchronous FIFO of completed rows; accepts a push while full when a pop happens in the same cycle.
module collector_row_fifo
  import systolic_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/systolic_result_collector.sv
// Stages per-PE results into rows, queues completed rows and streams them out.
// Define COLLECTOR_SAT_EN to saturate each element from DATA_W down to OUT_W at queue write.
module systolic_result_collector
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ARRAY_SIZE*ARRAY_SIZE-1:0]        finish,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_W-1:0] psum_flat,
  output logic                                    out_valid,
  input  logic                                    out_ready,
`ifdef COLLECTOR_SAT_EN
  output logic [ARRAY_SIZE*OUT_W-1:0]             out_row,
`else
  output logic [ARRAY_SIZE*DATA_W-1:0]            out_row,
`endif
  output logic [$clog2(ARRAY_SIZE)-1:0]           out_row_idx,
  output logic                                    overflow
);

  localparam int NN = ARRAY_SIZE * ARRAY_SIZE;
  localparam int IW = $clog2(ARRAY_SIZE);
`ifdef COLLECTOR_SAT_EN
  localparam int EW = OUT_W;
`else
  localparam int EW = DATA_W;
`endif
  localparam int ENT_W = IW + ARRAY_SIZE * EW;

  if (OUT_W > DATA_W) begin : g_out_w_check
    $error("OUT_W must not exceed DATA_W");
  end

`ifdef COLLECTOR_SAT_EN
  function automatic logic [OUT_W-1:0] sat_elem(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] hi, lo;
    hi = '0;
    hi[OUT_W-2:0] = '1;
    lo = ~hi;
    if (x > hi)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (x < lo) return {1'b1, {(OUT_W-1){1'b0}}};
    else             return x[OUT_W-1:0];
  endfunction
`endif

  logic signed [DATA_W-1:0] slot_q [NN];
  logic [NN-1:0]            got_q, got_d, cap;
  logic [ARRAY_SIZE-1:0]    pend_q, pend_d;
  logic                     ovf_q, ovf_d;
  logic                     push, push_any, pop, full, empty;
  logic [IW-1:0]            push_row;
  logic [ARRAY_SIZE*EW-1:0] elems;
  logic [ENT_W-1:0]         push_ent, head_ent;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;

  // A slot is locked once captured, and the whole row stays locked while it waits for the queue.
  always_comb begin
    got_d    = got_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    cap      = '0;
    push_any = 1'b0;
    push_row = '0;
    for (int k = 0; k < NN; k++) begin
      if (finish[k]) begin
        if (got_q[k] | pend_q[row_of(k, ARRAY_SIZE)]) begin
          ovf_d = 1'b1;
        end else begin
          cap[k]   = 1'b1;
          got_d[k] = 1'b1;
        end
      end
    end
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      if (&got_d[i*ARRAY_SIZE +: ARRAY_SIZE]) pend_d[i] = 1'b1;
    end
    for (int i = ARRAY_SIZE - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        push_any = 1'b1;
        push_row = IW'(i);
      end
    end
    push = push_any & (~full | pop);
    if (push) begin
      pend_d[push_row]                         = 1'b0;
      got_d[push_row*ARRAY_SIZE +: ARRAY_SIZE] = '0;
    end
  end

  always_comb begin
    elems = '0;
    for (int j = 0; j < ARRAY_SIZE; j++) begin
`ifdef COLLECTOR_SAT_EN
      elems[j*EW +: EW] = sat_elem(slot_q[int'(push_row)*ARRAY_SIZE + j]);
`else
      elems[j*EW +: EW] = slot_q[int'(push_row)*ARRAY_SIZE + j];
`endif
    end
    push_ent = {push_row, elems};
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NN; k++) begin
      if (cap[k]) slot_q[k] <= psum_flat[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      got_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      got_q  <= got_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  collector_row_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .dout_o  (head_ent),
    .full_o  (full),
    .empty_o (empty)
  );

  // Queue memory is not reset, so outputs are forced to zero while nothing is queued.
  assign out_row     = empty ? '0 : head_ent[ARRAY_SIZE*EW-1:0];
  assign out_row_idx = empty ? '0 : head_ent[ENT_W-1 -: IW];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector with hand-computed expected rows.
module tb_systolic_result_collector;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int FD = 4;
`ifdef COLLECTOR_SAT_EN
  localparam int EW = OW;
`else
  localparam int EW = DW;
`endif
  localparam int IW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*N-1:0]    finish = '0;
  logic [N*N*DW-1:0] psum_flat = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [N*EW-1:0]   out_row;
  logic [IW-1:0]     out_row_idx;
  logic              overflow;

  int     n_chk = 0;
  int     n_fail = 0;
  longint exp_e [N];

  always #5 clk = ~clk;

  systolic_result_collector #(
    .ARRAY_SIZE (N),
    .DATA_W     (DW),
    .OUT_W      (OW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .finish      (finish),
    .psum_flat   (psum_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .overflow    (overflow)
  );

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_psum(input int base);
    for (int k = 0; k < N*N; k++) psum_flat[k*DW +: DW] = DW'(base + k);
  endtask

  task automatic fill_exp(input int base, input int idx);
    for (int j = 0; j < N; j++) exp_e[j] = base + idx*N + j;
  endtask

  task automatic check_row(input string tag, input int idx);
    check_val({tag, "_idx"}, longint'(out_row_idx), idx);
    for (int j = 0; j < N; j++)
      check_val($sformatf("%s_e%0d", tag, j), longint'($signed(out_row[j*EW +: EW])), exp_e[j]);
  endtask

  task automatic wait_row(input string tag, input int idx);
    int t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    check_val({tag, "_valid"}, longint'(out_valid), 1);
    if (out_valid) check_row(tag, idx);
  endtask

  function automatic logic [N*N-1:0] diag(input int c);
    logic [N*N-1:0] m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i + j == c) m[i*N + j] = 1'b1;
    return m;
  endfunction

  function automatic logic [N*N-1:0] row_mask(input int i);
    logic [N*N-1:0] m = '0;
    m[i*N +: N] = '1;
    return m;
  endfunction

  initial begin
    // Reset state
    set_psum(100);
    tick();
    tick();
    check_val("rst_valid", longint'(out_valid), 0);
    check_val("rst_ovf", longint'(overflow), 0);
    fill_exp(0, 0);
    for (int j = 0; j < N; j++) exp_e[j] = 0;
    check_row("rst_row", 0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Diagonal wavefront: row i completes at edge i+3, visible after edge i+4
    for (int c = 0; c < 10; c++) begin
      finish = (c <= 6) ? diag(c) : '0;
      tick();
      check_val($sformatf("wave_valid_c%0d", c), longint'(out_valid), (c >= 4 && c <= 7) ? 1 : 0);
      if (c >= 4 && c <= 7) begin
        fill_exp(100, c - 4);
        check_row($sformatf("wave_c%0d", c), c - 4);
      end
    end
    finish = '0;

    // Every PE finishes in one cycle: rows drain on consecutive cycles in index order
    set_psum(200);
    finish = '1;
    tick();
    finish = '0;
    check_val("all_valid_e0", longint'(out_valid), 0);
    for (int r = 0; r < N; r++) begin
      tick();
      check_val($sformatf("all_valid_r%0d", r), longint'(out_valid), 1);
      fill_exp(200, r);
      check_row($sformatf("all_r%0d", r), r);
    end
    tick();
    check_val("all_valid_end", longint'(out_valid), 0);
    check_val("all_ovf", longint'(overflow), 0);

    // Back-pressure: four rows queued, two rows pending behind a full queue
    out_ready = 1'b0;
    set_psum(300);
    finish = '1;
    tick();
    finish = '0;
    repeat (6) tick();
    set_psum(400);
    finish = row_mask(0) | row_mask(1);
    tick();
    finish = '0;
    fill_exp(300, 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check_val($sformatf("bp_hold_valid%0d", s), longint'(out_valid), 1);
      check_row($sformatf("bp_hold%0d", s), 0);
    end
    check_val("bp_ovf", longint'(overflow), 0);
    out_ready = 1'b1;
    for (int m = 0; m < 6; m++) begin
      fill_exp(m < 4 ? 300 : 400, m % 4);
      wait_row($sformatf("bp_drain%0d", m), m % 4);
      tick();
    end
    check_val("bp_valid_end", longint'(out_valid), 0);
    check_val("bp_ovf_end", longint'(overflow), 0);

    // Double finish on PE 5: overflow sticks, first value is kept
    set_psum(500);
    psum_flat[5*DW +: DW] = DW'(555);
    finish = '0;
    finish[5] = 1'b1;
    tick();
    psum_flat[5*DW +: DW] = DW'(999);
    tick();
    finish = '0;
    check_val("dbl_ovf", longint'(overflow), 1);
    finish[4] = 1'b1;
    finish[6] = 1'b1;
    finish[7] = 1'b1;
    tick();
    finish = '0;
    fill_exp(500, 1);
    exp_e[1] = 555;
    wait_row("dbl_row", 1);
    tick();
    check_val("dbl_ovf_sticky", longint'(overflow), 1);

    // Reset with two rows queued and row 3 half staged
    out_ready = 1'b0;
    set_psum(600);
    finish = row_mask(0) | row_mask(2);
    finish[12] = 1'b1;
    finish[13] = 1'b1;
    tick();
    finish = '0;
    tick();
    tick();
    check_val("mid_valid_pre", longint'(out_valid), 1);
    rst_n = 1'b0;
    tick();
    check_val("mid_valid_rst", longint'(out_valid), 0);
    check_val("mid_ovf_rst", longint'(overflow), 0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_psum(700);
    finish = row_mask(1);
    finish[14] = 1'b1;
    finish[15] = 1'b1;
    tick();
    finish = '0;
    fill_exp(700, 1);
    wait_row("mid_row1", 1);
    tick();
    for (int s = 0; s < 3; s++) begin
      check_val($sformatf("mid_no_stale%0d", s), longint'(out_valid), 0);
      tick();
    end
    finish[12] = 1'b1;
    finish[13] = 1'b1;
    tick();
    finish = '0;
    fill_exp(700, 3);
    wait_row("mid_row3", 3);
    tick();
    check_val("mid_valid_end", longint'(out_valid), 0);

`ifdef COLLECTOR_SAT_EN
    // Saturation at queue write
    psum_flat[0*DW +: DW] = DW'(70000);
    psum_flat[1*DW +: DW] = DW'(-70000);
    psum_flat[2*DW +: DW] = DW'(1234);
    psum_flat[3*DW +: DW] = DW'(-1);
    finish = row_mask(0);
    tick();
    finish = '0;
    exp_e[0] = 32767;
    exp_e[1] = -32768;
    exp_e[2] = 1234;
    exp_e[3] = -1;
    wait_row("sat_row", 0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
